apb_master_bridge: RTL and testbench

- Upstream APB requester for the 8-bit peripheral bus; drives the RAM slave and one further slave.
- Converts a simple valid/ready command interface from the core-side interconnect into APB SETUP/ACCESS transfers.
- Muxes PREADY/PRDATA back from the selected slave and returns a single-cycle response.
- Bounds wait states with a timeout counter, so a hung slave cannot stall the requester.

---
 rtl/apb_master_bridge.sv | 184 ++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester for the 8-bit peripheral bus: turns valid/ready commands into
// SETUP/ACCESS transfers on two slaves and returns a one-cycle response.
module apb_master_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_sel,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY1,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic              PREADY2,
  input  logic [DATA_W-1:0] PRDATA2
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic               sel_r, sel_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               psel1_r, psel1_s;
  logic               psel2_r, psel2_s;
  logic               penable_r, penable_s;
  logic               pwrite_r, pwrite_s;
  logic [ADDR_W-1:0]  paddr_r, paddr_s;
  logic [DATA_W-1:0]  pwdata_r, pwdata_s;
  logic               rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0]  rsp_rdata_r, rsp_rdata_s;
  logic               rsp_err_r, rsp_err_s;
  logic               pready_s;
  logic [DATA_W-1:0]  prdata_s;

  // Route ready/data back from whichever slave the current transfer targets.
  always_comb begin
    if (sel_r) begin
      pready_s = PREADY2;
      prdata_s = PRDATA2;
    end else begin
      pready_s = PREADY1;
      prdata_s = PRDATA1;
    end
  end

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_s     = state_r;
    sel_s       = sel_r;
    cnt_s       = cnt_r;
    psel1_s     = psel1_r;
    psel2_s     = psel2_r;
    penable_s   = penable_r;
    pwrite_s    = pwrite_r;
    paddr_s     = paddr_r;
    pwdata_s    = pwdata_r;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = rsp_rdata_r;
    rsp_err_s   = rsp_err_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          pwrite_s = cmd_write;
          paddr_s  = cmd_addr;
          pwdata_s = cmd_wdata;
          sel_s    = cmd_sel[0];
          // Selects 2 and 3 have no slave behind them: fail without bus activity.
          if (cmd_sel[1] == 1'b0) begin
            state_s = ST_SETUP;
            psel1_s = ~cmd_sel[0];
            psel2_s = cmd_sel[0];
          end else begin
            state_s = ST_ERR;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_s   = ST_ACCESS;
        penable_s = 1'b1;
        cnt_s     = {CNT_W{1'b0}};
      end
      ST_ACCESS: begin
        if (pready_s) begin
          state_s     = ST_IDLE;
          psel1_s     = 1'b0;
          psel2_s     = 1'b0;
          penable_s   = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b0;
          rsp_rdata_s = pwrite_r ? {DATA_W{1'b0}} : prdata_s;
        end else if (cnt_r == CNT_LAST) begin
          // TIMEOUT ACCESS cycles without PREADY: abandon the transfer.
          state_s     = ST_IDLE;
          psel1_s     = 1'b0;
          psel2_s     = 1'b0;
          penable_s   = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          rsp_rdata_s = {DATA_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      ST_ERR: begin
        state_s     = ST_IDLE;
        rsp_valid_s = 1'b1;
        rsp_err_s   = 1'b1;
        rsp_rdata_s = {DATA_W{1'b0}};
      end
      default: begin
        state_s   = ST_IDLE;
        psel1_s   = 1'b0;
        psel2_s   = 1'b0;
        penable_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r     <= ST_IDLE;
      sel_r       <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      psel1_r     <= 1'b0;
      psel2_r     <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= {ADDR_W{1'b0}};
      pwdata_r    <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      sel_r       <= sel_s;
      cnt_r       <= cnt_s;
      psel1_r     <= psel1_s;
      psel2_r     <= psel2_s;
      penable_r   <= penable_s;
      pwrite_r    <= pwrite_s;
      paddr_r     <= paddr_s;
      pwdata_r    <= pwdata_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

  assign cmd_ready = (state_r == ST_IDLE);
  assign PSEL1     = psel1_r;
  assign PSEL2     = psel2_r;
  assign PENABLE   = penable_r;
  assign PWRITE    = pwrite_r;
  assign PADDR     = paddr_r;
  assign PWDATA    = pwdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Table-driven bench for apb_master_bridge with reset and mid-transfer reset sequences.
module tb_apb_master_bridge;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [1:0] cmd_sel = 2'd0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic       PREADY1 = 1'b0;
  logic [7:0] PRDATA1 = 8'h00;
  logic       PREADY2 = 1'b0;
  logic [7:0] PRDATA2 = 8'h00;

  int checks = 0;
  int failures = 0;

  apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY1(PREADY1), .PRDATA1(PRDATA1), .PREADY2(PREADY2), .PRDATA2(PRDATA2)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       write;
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         wait_n;     // ACCESS cycles with PREADY low before it rises
    logic [7:0] prdata1;
    logic [7:0] prdata2;
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         exp_acc;    // cycles with PSEL and PENABLE high
    int         exp_psel;   // cycles with the expected PSEL high
    int         exp_lat;    // negedges after accept edge until rsp_valid seen
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs_or();
    return {28'd0, PSEL1 | PSEL2 | PENABLE | PWRITE | (|PADDR) | (|PWDATA),
            rsp_valid, |rsp_rdata, rsp_err};
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where rsp_valid is seen.
  task automatic run_txn(input int idx);
    vec_t v;
    int acc, psel_n, wrong_psel, lat, bad_attr;
    logic done;
    v = tbl[idx];
    chk($sformatf("v%0d_cmd_ready", idx), {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_sel = v.sel;
    cmd_addr = v.addr; cmd_wdata = v.wdata;
    PRDATA1 = v.prdata1; PRDATA2 = v.prdata2;
    PREADY1 = 1'b0; PREADY2 = 1'b0;
    acc = 0; psel_n = 0; wrong_psel = 0; lat = 0; bad_attr = 0; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge PCLK);
      cmd_valid = 1'b0;
      cmd_addr = 8'hEE; cmd_wdata = 8'hDD; cmd_write = ~v.write; cmd_sel = 2'd2;
      if (PWRITE !== v.write || PADDR !== v.addr || PWDATA !== v.wdata) bad_attr++;
      if (rsp_valid) begin
        done = 1'b1;
        lat = c;
        PREADY1 = 1'b0; PREADY2 = 1'b0;
      end else begin
        if (v.sel == 2'd0 && PSEL1) psel_n++;
        else if (v.sel == 2'd1 && PSEL2) psel_n++;
        if ((v.sel != 2'd0 && PSEL1) || (v.sel != 2'd1 && PSEL2)) wrong_psel++;
        if (PENABLE && (PSEL1 || PSEL2)) acc++;
        // Selected slave answers once its wait count is spent; the other one toggles.
        if (v.sel == 2'd1) begin
          PREADY2 = (PENABLE && acc > v.wait_n);
          PREADY1 = ~PREADY1;
        end else begin
          PREADY1 = (PENABLE && acc > v.wait_n);
          PREADY2 = ~PREADY2;
        end
      end
    end
    if (!done) begin
      failures++;
      checks++;
      $display("FAIL v%0d_timeout: no rsp_valid within 40 cycles", idx);
    end else begin
      chk($sformatf("v%0d_lat", idx), lat, v.exp_lat);
      chk($sformatf("v%0d_err", idx), {31'd0, rsp_err}, {31'd0, v.exp_err});
      chk($sformatf("v%0d_rdata", idx), {24'd0, rsp_rdata}, {24'd0, v.exp_rdata});
      chk($sformatf("v%0d_acc", idx), acc, v.exp_acc);
      chk($sformatf("v%0d_psel", idx), psel_n, v.exp_psel);
      chk($sformatf("v%0d_wrong_psel", idx), wrong_psel, 32'd0);
      chk($sformatf("v%0d_attr_stable", idx), bad_attr, 32'd0);
      chk($sformatf("v%0d_bus_idle", idx), {29'd0, PSEL1, PSEL2, PENABLE}, 32'd0);
      chk($sformatf("v%0d_ready_back", idx), {31'd0, cmd_ready}, 32'd1);
    end
  endtask

  initial begin
    //        wr    sel    addr   wdata  wait p1     p2     err   rdata  acc psel lat
    tbl[0] = '{1'b1, 2'd0, 8'h3C, 8'hA5, 1,   8'h99, 8'hFF, 1'b0, 8'h00, 2,  3,   4};
    tbl[1] = '{1'b0, 2'd0, 8'h3C, 8'h00, 0,   8'hA5, 8'hFF, 1'b0, 8'hA5, 1,  2,   3};
    tbl[2] = '{1'b0, 2'd1, 8'h10, 8'h00, 255, 8'h12, 8'h34, 1'b1, 8'h00, 16, 17,  18};
    tbl[3] = '{1'b1, 2'd3, 8'h77, 8'h5A, 0,   8'h12, 8'h34, 1'b1, 8'h00, 0,  0,   2};
    tbl[4] = '{1'b0, 2'd1, 8'h20, 8'h00, 15,  8'h11, 8'h66, 1'b0, 8'h66, 16, 17,  18};
    tbl[5] = '{1'b0, 2'd2, 8'h55, 8'hAA, 0,   8'h12, 8'h34, 1'b1, 8'h00, 0,  0,   2};
    tbl[6] = '{1'b1, 2'd1, 8'hFF, 8'h00, 0,   8'h12, 8'h34, 1'b0, 8'h00, 1,  2,   3};
    tbl[7] = '{1'b0, 2'd1, 8'h42, 8'h00, 2,   8'h11, 8'hC3, 1'b0, 8'hC3, 3,  4,   5};

    // Reset with a command already pending.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = 2'd0;
    cmd_addr = 8'h3C; cmd_wdata = 8'hA5; PREADY1 = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_outputs_zero", outs_or(), 32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    chk("rst_accept_setup", {29'd0, PSEL1, PENABLE, cmd_ready}, 32'b100);
    @(negedge PCLK);
    chk("rst_accept_access", {29'd0, PSEL1, PENABLE, rsp_valid}, 32'b110);
    @(negedge PCLK);
    chk("rst_accept_rsp", {30'd0, rsp_valid, rsp_err}, 32'b10);
    PREADY1 = 1'b0;

    // Back-to-back table transactions.
    for (int i = 0; i < 8; i++) run_txn(i);

    // Response fields hold after the pulse.
    repeat (2) @(negedge PCLK);
    chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("hold_rsp_rdata", {24'd0, rsp_rdata}, 32'h0000_00C3);
    chk("hold_rsp_err", {31'd0, rsp_err}, 32'd0);

    // Reset in the middle of a write ACCESS phase.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = 2'd0;
    cmd_addr = 8'h3C; cmd_wdata = 8'hA5; PREADY1 = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("mid_in_access", {30'd0, PSEL1, PENABLE}, 32'b11);
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_outputs_zero", outs_or(), 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    begin
      int seen;
      seen = 0;
      PREADY1 = 1'b1;
      repeat (3) begin
        @(negedge PCLK);
        if (rsp_valid) seen++;
      end
      PRESETn = 1'b1;
      PREADY1 = 1'b0;
      repeat (2) begin
        @(negedge PCLK);
        if (rsp_valid) seen++;
      end
      chk("mid_rst_no_rsp", seen, 32'd0);
    end
    run_txn(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
